// File: rtl/dual_issue_unit_if.sv
// Fetch-pair, downstream stall/flush and issue-side signals for dual_issue_unit.
// slave: the issue unit. master: the fetch/pipeline side driving it.
interface dual_issue_unit_if;
  // Fetched pair, A older than B
  logic [31:0] instrA_IF;
  logic [31:0] instrB_IF;
  logic        validA_IF;
  logic        validB_IF;
  logic        pairValid_IF;
  logic        pipeA_IF;
  logic        pipeB_IF;
  // Dependency info: A's destination, B's sources
  logic [6:0]  rtA_IF;
  logic [6:0]  raB_IF;
  logic [6:0]  rbB_IF;
  logic [6:0]  rcB_IF;
  logic        wrA_IF;
  logic        useRaB_IF;
  logic        useRbB_IF;
  logic        useRcB_IF;
  // Downstream control
  logic        stallEven;
  logic        stallOdd;
  logic        flush;
  // Issue side
  logic        readyPair;
  logic [31:0] instrEven_ISS;
  logic [31:0] instrOdd_ISS;
  logic        validEven_ISS;
  logic        validOdd_ISS;
  logic [15:0] dualCount;

  modport slave (
    input  instrA_IF, instrB_IF, validA_IF, validB_IF, pairValid_IF, pipeA_IF, pipeB_IF,
    input  rtA_IF, raB_IF, rbB_IF, rcB_IF, wrA_IF, useRaB_IF, useRbB_IF, useRcB_IF,
    input  stallEven, stallOdd, flush,
    output readyPair, instrEven_ISS, instrOdd_ISS, validEven_ISS, validOdd_ISS, dualCount
  );

  modport master (
    output instrA_IF, instrB_IF, validA_IF, validB_IF, pairValid_IF, pipeA_IF, pipeB_IF,
    output rtA_IF, raB_IF, rbB_IF, rcB_IF, wrA_IF, useRaB_IF, useRbB_IF, useRcB_IF,
    output stallEven, stallOdd, flush,
    input  readyPair, instrEven_ISS, instrOdd_ISS, validEven_ISS, validOdd_ISS, dualCount
  );
endinterface

// File: rtl/dual_issue_unit.sv
// Dual-issue unit: buffers one fetched instruction pair and steers it onto the even/odd
// pipes, issuing both in one cycle when they use different pipes and B does not read A's
// result. Optional feature macro: DUAL_ISSUE_EN (undefined: A and B always issue in
// separate cycles and dualCount reads 0).
module dual_issue_unit (
  input logic             clk,
  input logic             reset,
  dual_issue_unit_if.slave bus
);

`ifdef DUAL_ISSUE_EN
  localparam bit DualEn = 1'b1;
`else
  localparam bit DualEn = 1'b0;
`endif

  localparam logic [1:0] StEmpty  = 2'd0;
  localparam logic [1:0] StPair   = 2'd1;
  localparam logic [1:0] StSecond = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] instr_a_q, instr_a_d;
  logic [31:0] instr_b_q, instr_b_d;
  logic        valid_b_q, valid_b_d;
  logic        pipe_a_q, pipe_a_d;
  logic        pipe_b_q, pipe_b_d;
  logic        hazard_q, hazard_d;

  logic stall_a, stall_b, pair_ok;
  logic present_a, present_b, issue_a, issue_b, all_done;
  logic ready_core, capture, hazard_in;

  assign stall_a = pipe_a_q ? bus.stallOdd : bus.stallEven;
  assign stall_b = pipe_b_q ? bus.stallOdd : bus.stallEven;
  assign pair_ok = DualEn && valid_b_q && (pipe_b_q != pipe_a_q) && !hazard_q;

  assign hazard_in = bus.wrA_IF && bus.validA_IF && bus.validB_IF &&
                     ((bus.useRaB_IF && (bus.raB_IF == bus.rtA_IF)) ||
                      (bus.useRbB_IF && (bus.rbB_IF == bus.rtA_IF)) ||
                      (bus.useRcB_IF && (bus.rcB_IF == bus.rtA_IF)));

  // Decide what is presented and what issues this cycle; B rides along only once A goes
  always_comb begin
    present_a = 1'b0;
    present_b = 1'b0;
    issue_a   = 1'b0;
    issue_b   = 1'b0;
    all_done  = 1'b0;
    case (state_q)
      StPair: begin
        present_a = !bus.flush;
        issue_a   = present_a && !stall_a;
        present_b = pair_ok && issue_a;
        issue_b   = present_b && !stall_b;
        all_done  = issue_a && (!valid_b_q || issue_b);
      end
      StSecond: begin
        present_b = !bus.flush;
        issue_b   = present_b && !stall_b;
        all_done  = issue_b;
      end
      default: ;
    endcase
  end

  // Ready when idle or draining completely this cycle (same-edge refill); never under flush
  assign ready_core    = !bus.flush && ((state_q == StEmpty) || all_done);
  assign bus.readyPair = reset || ready_core;
  assign capture       = bus.pairValid_IF && ready_core;

  // Route presented instructions onto pipes; unpresented pipes read as zero
  always_comb begin
    bus.validEven_ISS = 1'b0;
    bus.validOdd_ISS  = 1'b0;
    bus.instrEven_ISS = 32'd0;
    bus.instrOdd_ISS  = 32'd0;
    if (present_a) begin
      if (pipe_a_q) begin
        bus.validOdd_ISS = 1'b1;
        bus.instrOdd_ISS = instr_a_q;
      end else begin
        bus.validEven_ISS = 1'b1;
        bus.instrEven_ISS = instr_a_q;
      end
    end
    if (present_b) begin
      if (pipe_b_q) begin
        bus.validOdd_ISS = 1'b1;
        bus.instrOdd_ISS = instr_b_q;
      end else begin
        bus.validEven_ISS = 1'b1;
        bus.instrEven_ISS = instr_b_q;
      end
    end
  end

  // Next state and buffer: flush wins, then drain progress, then capture of a new pair
  always_comb begin
    state_d   = state_q;
    instr_a_d = instr_a_q;
    instr_b_d = instr_b_q;
    valid_b_d = valid_b_q;
    pipe_a_d  = pipe_a_q;
    pipe_b_d  = pipe_b_q;
    hazard_d  = hazard_q;
    if (bus.flush) begin
      state_d   = StEmpty;
      instr_a_d = 32'd0;
      instr_b_d = 32'd0;
      valid_b_d = 1'b0;
      pipe_a_d  = 1'b0;
      pipe_b_d  = 1'b0;
      hazard_d  = 1'b0;
    end else begin
      case (state_q)
        StPair: begin
          if (issue_a) begin
            state_d = (valid_b_q && !issue_b) ? StSecond : StEmpty;
          end
        end
        StSecond: begin
          if (issue_b) begin
            state_d = StEmpty;
          end
        end
        default: ;
      endcase
      if (capture) begin
        instr_a_d = bus.instrA_IF;
        instr_b_d = bus.instrB_IF;
        valid_b_d = bus.validB_IF;
        pipe_a_d  = bus.pipeA_IF;
        pipe_b_d  = bus.pipeB_IF;
        hazard_d  = hazard_in;
        if (bus.validA_IF) begin
          state_d = StPair;
        end else if (bus.validB_IF) begin
          state_d = StSecond;
        end else begin
          state_d = StEmpty;
        end
      end
    end
  end

  // Pair buffer and FSM state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StEmpty;
      instr_a_q <= 32'd0;
      instr_b_q <= 32'd0;
      valid_b_q <= 1'b0;
      pipe_a_q  <= 1'b0;
      pipe_b_q  <= 1'b0;
      hazard_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_a_q <= instr_a_d;
      instr_b_q <= instr_b_d;
      valid_b_q <= valid_b_d;
      pipe_a_q  <= pipe_a_d;
      pipe_b_q  <= pipe_b_d;
      hazard_q  <= hazard_d;
    end
  end

`ifdef DUAL_ISSUE_EN
  logic [15:0] dual_count_q;

  // Count edges where both instructions of a pair issue together; wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dual_count_q <= 16'd0;
    end else if (issue_a && issue_b) begin
      dual_count_q <= dual_count_q + 16'd1;
    end
  end

  assign bus.dualCount = dual_count_q;
`else
  assign bus.dualCount = 16'd0;
`endif

endmodule
